// File: rtl/sliding_window_pkg.sv
// sliding_window_pkg: shared widths, defaults and coefficient helpers for the convolution window
package sliding_window_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_KERNEL_WIDTH = 3;
  localparam int DEF_KERNEL_HEIGHT = 3;
  localparam logic [287:0] DEF_KERNEL_COEF =
    288'h000100020003000400050006000700080009000A000B000C000D000E000F001000110012;
  function automatic int coef_width(input int dw);
    return 2 * dw;
  endfunction
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction
  // Sign-extends entry i of a packed coefficient vector (up to 1024 bits, entries up to 64 bits)
  function automatic logic signed [63:0] coef_at(input logic [1023:0] k, input int i, input int cw);
    logic [63:0] s;
    s = k[i*cw +: 64];
    return $signed(s << (64 - cw)) >>> (64 - cw);
  endfunction
endpackage

// File: rtl/sliding_window_mac.sv
// sliding_window_mac: combinational full-width signed MAC of the window against fixed coefficients
module sliding_window_mac
  import sliding_window_pkg::*;
#(
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COEF_WIDTH = coef_width(DATA_WIDTH),
  parameter int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, KERNEL_WIDTH * KERNEL_HEIGHT),
  parameter logic [KERNEL_WIDTH*KERNEL_HEIGHT*COEF_WIDTH-1:0] KERNEL_COEF = DEF_KERNEL_COEF
) (
  input  logic [KERNEL_WIDTH*KERNEL_HEIGHT*DATA_WIDTH-1:0] window,
  output logic signed [ACC_WIDTH-1:0]                      sum
);
  localparam int TAPS = KERNEL_WIDTH * KERNEL_HEIGHT;
  logic signed [DATA_WIDTH-1:0] px;
  logic signed [COEF_WIDTH-1:0] cf;
  logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
  always_comb begin
    sum = '0;
    px = '0;
    cf = '0;
    prod = '0;
    for (int i = 0; i < TAPS; i++) begin
      px = window[i*DATA_WIDTH +: DATA_WIDTH];
      cf = COEF_WIDTH'(coef_at(1024'(KERNEL_COEF), i, COEF_WIDTH));
      prod = px * cf;
      sum = sum + ACC_WIDTH'(prod);
    end
  end
endmodule

// File: rtl/sliding_window.sv
// sliding_window: row shift-register window feeding a registered, wrapping convolution output
module sliding_window
  import sliding_window_pkg::*;
#(
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [KERNEL_WIDTH*KERNEL_HEIGHT*coef_width(DATA_WIDTH)-1:0] KERNEL_COEF = DEF_KERNEL_COEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]              data_out
);
  localparam int COEF_WIDTH = coef_width(DATA_WIDTH);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, KERNEL_WIDTH * KERNEL_HEIGHT);
  logic [KERNEL_HEIGHT-1:0][KERNEL_WIDTH*DATA_WIDTH-1:0] win;
  logic signed [ACC_WIDTH-1:0] sum;
  sliding_window_mac #(
    .KERNEL_WIDTH (KERNEL_WIDTH),
    .KERNEL_HEIGHT(KERNEL_HEIGHT),
    .DATA_WIDTH   (DATA_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .KERNEL_COEF  (KERNEL_COEF)
  ) u_mac (
    .window(win),
    .sum   (sum)
  );
  // Row 0 is newest; the sum is taken from the window as it stands before this edge's shift
  always_ff @(posedge clk) begin
    if (reset) begin
      win <= '0;
      data_out <= '0;
    end else begin
      win <= {win[KERNEL_HEIGHT-2:0], data_in};
      data_out <= sum[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_sliding_window.sv
// tb_sliding_window: scoreboard bench for default and all-ones coefficient windows
module tb_sliding_window;
  localparam logic [287:0] DEF_K =
    288'h000100020003000400050006000700080009000A000B000C000D000E000F001000110012;
  localparam logic [287:0] ONES_K = {9{32'h0000_0001}};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [47:0] data_in = '0;
  logic [15:0] out0, out1;
  logic [2:0][47:0] mw = '0;
  logic [15:0] q0[$], q1[$];
  int checks = 0;
  int failures = 0;
  sliding_window dut0 (.clk(clk), .reset(reset), .data_in(data_in), .data_out(out0));
  sliding_window #(.KERNEL_COEF(ONES_K)) dut1 (.clk(clk), .reset(reset), .data_in(data_in), .data_out(out1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [2:0][47:0] w, input logic [287:0] k);
    logic signed [63:0] s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += 64'($signed(w[r][c*16 +: 16])) * 64'($signed(k[(r*3+c)*32 +: 32]));
    return s[15:0];
  endfunction
  task automatic step(input logic [47:0] row, input logic rst);
    data_in = row;
    reset = rst;
    if (rst) begin
      q0.push_back(16'h0);
      q1.push_back(16'h0);
      mw = '0;
    end else begin
      q0.push_back(model(mw, DEF_K));
      q1.push_back(model(mw, ONES_K));
      mw = {mw[1:0], row};
    end
    @(posedge clk);
    #1;
    check("out_default", out0, q0.pop_front());
    check("out_ones", out1, q1.pop_front());
  endtask
  function automatic logic [47:0] rnd();
    return 48'({$urandom, $urandom});
  endfunction
  initial begin
    step(rnd(), 1'b1);
    step(rnd(), 1'b1);
    check("reset_out", out0, 0);
    check("reset_win", 64'(|dut0.win), 0);
    step(48'h0000_0000_0001, 1'b0);
    check("imp_first", out0, 16'h0000);
    step('0, 1'b0); check("imp_r0", out0, 16'h0012);
    step('0, 1'b0); check("imp_r1", out0, 16'h000C);
    step('0, 1'b0); check("imp_r2", out0, 16'h0006);
    step('0, 1'b0); check("imp_done", out0, 16'h0000);
    step(48'h0001_0000_0000, 1'b0);
    step('0, 1'b0); check("col2_r0", out0, 16'h000E);
    step('0, 1'b0); check("col2_r1", out0, 16'h0008);
    step('0, 1'b0); check("col2_r2", out0, 16'h0002);
    step('0, 1'b0); check("col2_done", out0, 16'h0000);
    step(rnd(), 1'b1);
    step({3{16'hFFFF}}, 1'b0); check("neg_fill", out1, 16'h0000);
    step({3{16'hFFFF}}, 1'b0); check("neg_m3", out1, 16'hFFFD);
    step({3{16'hFFFF}}, 1'b0); check("neg_m6", out1, 16'hFFFA);
    step({3{16'h7FFF}}, 1'b0); check("neg_m9", out1, 16'hFFF7);
    for (int i = 0; i < 4; i++) step({3{16'h7FFF}}, 1'b0);
    for (int i = 0; i < 10; i++) step(rnd(), 1'b0);
    step(rnd(), 1'b1);
    check("mid_reset_out", out0, 0);
    check("mid_reset_win", 64'(|dut0.win), 0);
    for (int i = 0; i < 100; i++) step(rnd(), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
